// File: rtl/mem_port_arbiter_if.sv
// Access-width type and the bundled programmer/core/memory signals of mem_port_arbiter.
// The memory byte-address width ADDR_W is set on the interface instance.

package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;
endpackage

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    import mem_port_arbiter_pkg::*;

    logic              prog_valid_i;
    logic              prog_ready_o;
    logic [ADDR_W-1:0] prog_addr_i;
    logic [7:0]        prog_data_i;

    logic              core_req_i;
    logic              core_gnt_o;
    logic              core_we_i;
    mem_width_t        core_width_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [31:0]       core_wdata_i;
    logic              core_rvalid_o;
    logic [31:0]       core_rdata_o;

    logic [ADDR_W-1:0] mem_addr_o;
    mem_width_t        mem_width_o;
    logic              mem_we_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    logic              prog_active_o;

    // Arbiter side.
    modport slave (
        input  prog_valid_i, prog_addr_i, prog_data_i,
        input  core_req_i, core_we_i, core_width_i, core_addr_i, core_wdata_i,
        input  mem_rdata_i,
        output prog_ready_o, core_gnt_o, core_rvalid_o, core_rdata_o,
        output mem_addr_o, mem_width_o, mem_we_o, mem_wdata_o, prog_active_o
    );

    // Requester / memory side.
    modport master (
        output prog_valid_i, prog_addr_i, prog_data_i,
        output core_req_i, core_we_i, core_width_i, core_addr_i, core_wdata_i,
        output mem_rdata_i,
        input  prog_ready_o, core_gnt_o, core_rvalid_o, core_rdata_o,
        input  mem_addr_o, mem_width_o, mem_we_o, mem_wdata_o, prog_active_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the JTAG byte programmer and the core requester.
// Define MEM_ARB_RR_EN to alternate idle-state conflicts instead of always favouring the programmer.

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int PROG_HOLD = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROG  = 2'd1,
        ST_YIELD = 2'd2
    } state_t;

    localparam int HOLD_W  = $clog2(PROG_HOLD + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(PROG_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [RD_LAT-1:0]  rd_pipe_q, rd_pipe_d;

    logic prog_gnt;
    logic core_gnt;
    logic yield_req;
    logic rr_core_first;
    logic rd_issue;

    assign yield_req = (burst_cnt_q == BURST_MAX) && bus.core_req_i;
    assign rd_issue  = core_gnt & ~bus.core_we_i;

`ifdef MEM_ARB_RR_EN
    logic last_prog_q, last_prog_d;

    assign rr_core_first = bus.core_req_i & last_prog_q;

    always_comb begin
        last_prog_d = last_prog_q;
        if (prog_gnt) begin
            last_prog_d = 1'b1;
        end else if (core_gnt) begin
            last_prog_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_prog_q <= 1'b0;
        end else begin
            last_prog_q <= last_prog_d;
        end
    end
`else
    assign rr_core_first = 1'b0;
`endif

    // Read-valid shift register: the read address is already at the memory, so only the flag travels.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
        if (gi == 0) begin : g_head
            assign rd_pipe_d[gi] = rd_issue;
        end else begin : g_tail
            assign rd_pipe_d[gi] = rd_pipe_q[gi-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            burst_cnt_q <= '0;
            rd_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pipe_q   <= rd_pipe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (prog_gnt) begin
                    state_d     = ST_PROG;
                    hold_cnt_d  = HOLD_LOAD;
                    burst_cnt_d = BURST_ONE;
                end
            end
            ST_PROG: begin
                if (yield_req) begin
                    state_d = ST_YIELD;
                end else if (prog_gnt) begin
                    hold_cnt_d = HOLD_LOAD;
                    if (burst_cnt_q != BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + BURST_ONE;
                    end
                end else if (hold_cnt_q <= HOLD_ONE) begin
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_ONE;
                end
            end
            ST_YIELD: begin
                state_d     = ST_PROG;
                hold_cnt_d  = HOLD_LOAD;
                burst_cnt_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        prog_gnt = 1'b0;
        core_gnt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.prog_valid_i && !rr_core_first) begin
                    prog_gnt = 1'b1;
                end else if (bus.core_req_i) begin
                    core_gnt = 1'b1;
                end
            end
            ST_PROG:  prog_gnt = bus.prog_valid_i & ~yield_req;
            ST_YIELD: core_gnt = bus.core_req_i;
            default:  ;
        endcase
        // Reset is asynchronous, so the grants must drop combinationally too.
        if (rst_i) begin
            prog_gnt = 1'b0;
            core_gnt = 1'b0;
        end

        bus.prog_ready_o  = prog_gnt;
        bus.core_gnt_o    = core_gnt;
        bus.mem_we_o      = prog_gnt | (core_gnt & bus.core_we_i);
        bus.mem_addr_o    = prog_gnt ? bus.prog_addr_i : bus.core_addr_i;
        bus.mem_width_o   = (prog_gnt || rst_i) ? BYTE : bus.core_width_i;
        bus.mem_wdata_o   = rst_i    ? 32'd0 :
                            prog_gnt ? {24'd0, bus.prog_data_i} : bus.core_wdata_i;
        bus.prog_active_o = (state_q != ST_IDLE);
        bus.core_rvalid_o = rd_pipe_q[RD_LAT-1];
        bus.core_rdata_o  = rd_pipe_q[RD_LAT-1] ? bus.mem_rdata_i : 32'd0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a byte-array memory stub and
// a transaction-level reference model of the arbitration rules.

module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int RD_LAT    = 1;
    localparam int PROG_HOLD = 8;
    localparam int MAX_BURST = 16;
    localparam int DEPTH     = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .RD_LAT   (RD_LAT),
        .PROG_HOLD(PROG_HOLD),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Memory stub: little-endian byte array, registered read of RD_LAT cycles.
    bit   [7:0]  stub_mem [DEPTH];
    logic [31:0] stub_pipe [RD_LAT];

    function automatic logic [ADDR_W-1:0] ofs(input logic [ADDR_W-1:0] a, input int k);
        return a + ADDR_W'(k);
    endfunction

    function automatic logic [31:0] stub_word(input logic [ADDR_W-1:0] a);
        return {stub_mem[ofs(a, 3)], stub_mem[ofs(a, 2)], stub_mem[ofs(a, 1)], stub_mem[a]};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we_o === 1'b1) begin
            stub_mem[bus.mem_addr_o] <= bus.mem_wdata_o[7:0];
            if (bus.mem_width_o != BYTE) stub_mem[ofs(bus.mem_addr_o, 1)] <= bus.mem_wdata_o[15:8];
            if (bus.mem_width_o == WORD) begin
                stub_mem[ofs(bus.mem_addr_o, 2)] <= bus.mem_wdata_o[23:16];
                stub_mem[ofs(bus.mem_addr_o, 3)] <= bus.mem_wdata_o[31:24];
            end
        end
        stub_pipe[0] <= stub_word(bus.mem_addr_o);
        for (int i = 1; i < RD_LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
    end
    assign bus.mem_rdata_i = stub_pipe[RD_LAT-1];

    // Reference model: lock status, beats since start/yield, idle run since last beat.
    bit          locked, in_yield, last_prog;
    int          idle_run, beats;
    bit [7:0]    ref_mem [DEPTH];
    bit          exp_v [$];
    logic [31:0] exp_d [$];
    bit          e_pg, e_cg;

    logic        obs_pr, obs_cg, obs_act, obs_rv;
    logic [31:0] obs_rd;

    function automatic logic [31:0] ref_word(input logic [ADDR_W-1:0] a);
        return {ref_mem[ofs(a, 3)], ref_mem[ofs(a, 2)], ref_mem[ofs(a, 1)], ref_mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        locked = 0; in_yield = 0; last_prog = 0; idle_run = 0; beats = 0;
        exp_v.delete();
        exp_d.delete();
        for (int i = 0; i < RD_LAT; i++) begin
            exp_v.push_back(1'b0);
            exp_d.push_back(32'd0);
        end
    endtask

    task automatic eval_expect();
        bit core_first;
        core_first = 1'b0;
        e_pg = 0;
        e_cg = 0;
`ifdef MEM_ARB_RR_EN
        core_first = (bus.core_req_i === 1'b1) && last_prog;
`endif
        if (!locked) begin
            if (bus.prog_valid_i === 1'b1 && !core_first) e_pg = 1;
            else if (bus.core_req_i === 1'b1) e_cg = 1;
        end else if (in_yield) begin
            e_cg = (bus.core_req_i === 1'b1);
        end else if (!(beats == MAX_BURST && bus.core_req_i === 1'b1)) begin
            e_pg = (bus.prog_valid_i === 1'b1);
        end
    endtask

    task automatic commit();
        logic [ADDR_W-1:0] a;
        exp_v.push_back(e_cg && bus.core_we_i === 1'b0);
        exp_d.push_back(ref_word(bus.core_addr_i));
        if (e_pg) begin
            ref_mem[bus.prog_addr_i] = bus.prog_data_i;
        end else if (e_cg && bus.core_we_i === 1'b1) begin
            a = bus.core_addr_i;
            ref_mem[a] = bus.core_wdata_i[7:0];
            if (bus.core_width_i != BYTE) ref_mem[ofs(a, 1)] = bus.core_wdata_i[15:8];
            if (bus.core_width_i == WORD) begin
                ref_mem[ofs(a, 2)] = bus.core_wdata_i[23:16];
                ref_mem[ofs(a, 3)] = bus.core_wdata_i[31:24];
            end
        end
        if (e_pg) last_prog = 1;
        else if (e_cg) last_prog = 0;

        if (!locked) begin
            if (e_pg) begin
                locked = 1; beats = 1; idle_run = 0;
            end
        end else if (in_yield) begin
            in_yield = 0; beats = 0; idle_run = 0;
        end else if (beats == MAX_BURST && bus.core_req_i === 1'b1) begin
            in_yield = 1;
        end else if (bus.prog_valid_i === 1'b1) begin
            beats    = (beats < MAX_BURST) ? beats + 1 : MAX_BURST;
            idle_run = 0;
        end else begin
            idle_run++;
            if (idle_run == PROG_HOLD) locked = 0;
        end
    endtask

    // One clock: called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [31:0] x_addr, x_wdata;
        logic [31:0] x_width;
        logic        x_we;
        bit          rv;
        logic [31:0] rd;
        #1;
        eval_expect();
        x_we    = e_pg | (e_cg & bus.core_we_i);
        x_addr  = e_pg ? 32'(bus.prog_addr_i) : 32'(bus.core_addr_i);
        x_width = e_pg ? 32'(BYTE) : 32'(bus.core_width_i);
        x_wdata = e_pg ? {24'd0, bus.prog_data_i} : bus.core_wdata_i;
        rv = exp_v.pop_front();
        rd = exp_d.pop_front();
        obs_pr  = bus.prog_ready_o;
        obs_cg  = bus.core_gnt_o;
        obs_act = bus.prog_active_o;
        obs_rv  = bus.core_rvalid_o;
        obs_rd  = bus.core_rdata_o;
        chk("prog_ready", 32'(obs_pr), 32'(e_pg));
        chk("core_gnt", 32'(obs_cg), 32'(e_cg));
        chk("one_grant", 32'(obs_pr & obs_cg), 32'd0);
        chk("mem_we", 32'(bus.mem_we_o), 32'(x_we));
        chk("mem_addr", 32'(bus.mem_addr_o), x_addr);
        chk("mem_width", 32'(bus.mem_width_o), x_width);
        chk("mem_wdata", bus.mem_wdata_o, x_wdata);
        chk("prog_active", 32'(obs_act), 32'(locked));
        chk("core_rvalid", 32'(obs_rv), 32'(rv));
        if (rv) chk("core_rdata", obs_rd, rd);
        if (obs_pr === 1'b1)
            $display("[%0t] prog write addr=0x%03h data=0x%02h", $time, bus.prog_addr_i, bus.prog_data_i);
        if (obs_cg === 1'b1)
            $display("[%0t] core %s width=%0d addr=0x%03h wdata=0x%08h", $time,
                     bus.core_we_i ? "write" : "read", bus.core_width_i, bus.core_addr_i, bus.core_wdata_i);
        if (obs_rv === 1'b1)
            $display("[%0t] core read data=0x%08h", $time, obs_rd);
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(bus.prog_ready_o), 32'd0);
        chk({tag, "_gnt"}, 32'(bus.core_gnt_o), 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we_o), 32'd0);
        chk({tag, "_width"}, 32'(bus.mem_width_o), 32'(BYTE));
        chk({tag, "_addr"}, 32'(bus.mem_addr_o), 32'(bus.core_addr_i));
        chk({tag, "_wdata"}, bus.mem_wdata_o, 32'd0);
        chk({tag, "_rvalid"}, 32'(bus.core_rvalid_o), 32'd0);
        chk({tag, "_rdata"}, bus.core_rdata_o, 32'd0);
        chk({tag, "_active"}, 32'(bus.prog_active_o), 32'd0);
    endtask

    initial begin
        int nb, ny, dens;
        int yat [2];

        // Reset with every request asserted: all grants must stay off.
        rst = 1'b1;
        bus.prog_valid_i = 1'b1;
        bus.prog_addr_i  = 10'h2AA;
        bus.prog_data_i  = 8'h5A;
        bus.core_req_i   = 1'b1;
        bus.core_we_i    = 1'b1;
        bus.core_width_i = WORD;
        bus.core_addr_i  = 10'h155;
        bus.core_wdata_i = 32'h12345678;
        repeat (2) @(negedge clk);
        #1 chk_reset("reset");
        @(negedge clk);
        bus.prog_valid_i = 1'b0;
        bus.core_req_i   = 1'b0;
        bus.core_we_i    = 1'b0;
        model_reset();
        rst = 1'b0;

        // Programmer loads A0..A3, lock holds for PROG_HOLD idle cycles, then core reads back.
        bus.prog_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.prog_addr_i = 10'(k);
            bus.prog_data_i = 8'(8'hA0 + k);
            cycle();
            chk("t1_beat_ready", 32'(obs_pr), 32'd1);
        end
        bus.prog_valid_i = 1'b0;
        for (int k = 0; k < PROG_HOLD; k++) begin
            cycle();
            chk("t1_active_hold", 32'(obs_act), 32'd1);
        end
        bus.core_req_i   = 1'b1;
        bus.core_we_i    = 1'b0;
        bus.core_width_i = WORD;
        bus.core_addr_i  = 10'd0;
        cycle();
        chk("t1_active_dropped", 32'(obs_act), 32'd0);
        chk("t1_read_gnt", 32'(obs_cg), 32'd1);
        bus.core_req_i = 1'b0;
        cycle();
        chk("t1_rvalid", 32'(obs_rv), 32'd1);
        chk("t1_rdata", obs_rd, 32'hA3A2A1A0);

        // Core word write then read back.
        bus.core_req_i   = 1'b1;
        bus.core_we_i    = 1'b1;
        bus.core_addr_i  = 10'd4;
        bus.core_wdata_i = 32'h0DEFACED;
        cycle();
        chk("t2_write_gnt", 32'(obs_cg), 32'd1);
        bus.core_we_i = 1'b0;
        cycle();
        chk("t2_read_gnt", 32'(obs_cg), 32'd1);
        bus.core_req_i = 1'b0;
        cycle();
        chk("t2_rvalid", 32'(obs_rv), 32'd1);
        chk("t2_rdata", obs_rd, 32'h0DEFACED);

        // 40-beat stream with the core requesting throughout.
        bus.prog_valid_i = 1'b1;
        bus.core_req_i   = 1'b1;
        bus.core_we_i    = 1'b0;
        bus.core_addr_i  = 10'd0;
        nb = 0; ny = 0; yat[0] = -1; yat[1] = -1;
        for (int c = 0; c < 100 && nb < 40; c++) begin
            bus.prog_addr_i = 10'(16 + nb);
            bus.prog_data_i = 8'(nb);
            cycle();
            if (obs_cg === 1'b1) begin
                if (ny < 2) yat[ny] = nb;
                ny++;
            end
            if (obs_pr === 1'b1) nb++;
        end
        chk("t3_beats", 32'(nb), 32'd40);
        chk("t3_yields", 32'(ny), 32'd2);
        chk("t3_yield1_at", 32'(yat[0]), 32'd16);
        chk("t3_yield2_at", 32'(yat[1]), 32'd32);
        bus.prog_valid_i = 1'b0;
        bus.core_req_i   = 1'b0;
        repeat (PROG_HOLD + 1) cycle();
        // Back-to-back word reads over the streamed bytes.
        bus.core_req_i = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            logic [7:0] n;
            if (i == 10) bus.core_req_i = 1'b0;
            else bus.core_addr_i = 10'(16 + 4 * i);
            cycle();
            if (i > 0) begin
                n = 8'(4 * (i - 1));
                chk("t3_readback_rvalid", 32'(obs_rv), 32'd1);
                chk("t3_readback_data", obs_rd, {n + 8'd3, n + 8'd2, n + 8'd1, n});
            end
        end

        // Idle-state conflict after a programmer grant.
        bus.prog_valid_i = 1'b1;
        bus.prog_addr_i  = 10'd200;
        bus.prog_data_i  = 8'h11;
        cycle();
        bus.prog_valid_i = 1'b0;
        repeat (PROG_HOLD) cycle();
        bus.prog_valid_i = 1'b1;
        bus.prog_data_i  = 8'h77;
        bus.core_req_i   = 1'b1;
        bus.core_addr_i  = 10'd200;
        cycle();
`ifdef MEM_ARB_RR_EN
        chk("t4_conflict_ready", 32'(obs_pr), 32'd0);
        chk("t4_conflict_gnt", 32'(obs_cg), 32'd1);
`else
        chk("t4_conflict_ready", 32'(obs_pr), 32'd1);
        chk("t4_conflict_gnt", 32'(obs_cg), 32'd0);
`endif
        bus.prog_valid_i = 1'b0;
        bus.core_req_i   = 1'b0;
        repeat (PROG_HOLD + 1) cycle();

        // Reset during the yield cycle with a read being granted.
        bus.prog_valid_i = 1'b1;
        bus.core_req_i   = 1'b1;
        bus.core_we_i    = 1'b0;
        bus.core_addr_i  = 10'd8;
        nb = 0;
        for (int c = 0; c < 40 && nb < MAX_BURST; c++) begin
            bus.prog_addr_i = 10'(300 + nb);
            bus.prog_data_i = 8'(nb) ^ 8'h3C;
            cycle();
            if (obs_pr === 1'b1) nb++;
        end
        cycle();
        chk("t5_pre_yield_ready", 32'(obs_pr), 32'd0);
        #1 chk("t5_yield_gnt", 32'(bus.core_gnt_o), 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset("t5_async");
        repeat (2) begin
            @(posedge clk);
            #1 chk("t5_rvalid_in_reset", 32'(bus.core_rvalid_o), 32'd0);
        end
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        nb = 0; ny = 0; yat[0] = -1;
        for (int c = 0; c < 40 && ny == 0; c++) begin
            bus.prog_addr_i = 10'(400 + nb);
            bus.prog_data_i = 8'(nb);
            cycle();
            if (obs_cg === 1'b1) begin
                yat[0] = nb;
                ny++;
            end
            if (obs_pr === 1'b1) nb++;
        end
        chk("t5_restart_yield_at", 32'(yat[0]), 32'd16);
        bus.prog_valid_i = 1'b0;
        bus.core_req_i   = 1'b0;
        repeat (PROG_HOLD + 2) cycle();

        // Randomized traffic with varying programmer density.
        dens = 2;
        for (int n = 0; n < 480; n++) begin
            if (n % 40 == 0) dens = int'($urandom_range(0, 4));
            bus.prog_valid_i = (int'($urandom_range(0, 3)) < dens);
            bus.prog_addr_i  = 10'($urandom_range(0, 63));
            bus.prog_data_i  = 8'($urandom);
            bus.core_req_i   = 1'($urandom_range(0, 1));
            bus.core_we_i    = 1'($urandom_range(0, 1));
            bus.core_width_i = mem_width_t'(2'($urandom_range(0, 2)));
            bus.core_addr_i  = 10'($urandom_range(0, 63));
            bus.core_wdata_i = $urandom;
            cycle();
        end
        bus.prog_valid_i = 1'b0;
        bus.core_req_i   = 1'b0;
        repeat (RD_LAT + 2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
